lane_sprite_mixer: RTL

- Parametrised successor to the two-lane fixed OR colour merge in the top level.
- Combines NCH lane pattern outputs (4-bit sprite codes, one per lane, per pixel) into one RGB pixel for the vga module.
- Adds per-lane enable, priority / OR / additive-blend modes, background colour and per-lane blink.
- Sits between the pattern instances and the vga module's R_in/G_in/B_in; runs on CLOCK_25, pixel-aligned to next_x/next_y.

---
 rtl/lane_sprite_mixer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/lane_sprite_mixer.sv
// Per-pixel compositor: merges NCH lane sprite codes into one RGB pixel for the vga module.
// Two-stage pipeline; configuration is frame-shadowed and latched at each (0,0) request.
module lane_sprite_mixer #(
  parameter int unsigned NCH          = 4,
  parameter int unsigned CDEPTH       = 8,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned BLINK_FRAMES = 15
) (
  input  logic                  CLOCK_25,
  input  logic                  reset,
  input  logic [4*NCH-1:0]      sprite_in,
  input  logic [9:0]            next_x,
  input  logic [9:0]            next_y,
  input  logic [NCH-1:0]        ch_enable,
  input  logic [NCH-1:0]        blink_mask,
  input  logic [1:0]            mode,
  input  logic [3*CDEPTH-1:0]   bg_color,
  output logic [CDEPTH-1:0]     R_in,
  output logic [CDEPTH-1:0]     G_in,
  output logic [CDEPTH-1:0]     B_in,
  output logic                  pix_valid,
  output logic                  frame_start
);

  localparam int unsigned BW = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
  localparam logic [BW-1:0]     BlinkLast = BW'(2 * BLINK_FRAMES - 1);
  localparam logic [BW-1:0]     BlinkHalf = BW'(BLINK_FRAMES);
  localparam logic [9:0]        HAct      = 10'(H_ACTIVE);
  localparam logic [9:0]        VAct      = 10'(V_ACTIVE);
  localparam logic [CDEPTH-1:0] Half      = CDEPTH'(1) << (CDEPTH - 1);
  localparam logic [CDEPTH-1:0] Fs        = '1;

  // Frame shadow registers
  logic [1:0]          mode_q;
  logic [NCH-1:0]      en_q, bmask_q;
  logic [3*CDEPTH-1:0] bg_q;
  logic [BW-1:0]       blink_q, blink_d;

  // Stage 1: per-lane {B,G,R} already masked by visibility
  logic [3*NCH-1:0]    lane_q, lane_d;
  logic                act_q, first_q;
  logic                first, active, blink_off;
  logic [NCH-1:0]      en_eff, bmask_eff;

  // Stage 2 next-state
  logic [CDEPTH-1:0]   col_d [3];

  always_comb begin
    first     = (next_x == 10'd0) && (next_y == 10'd0);
    active    = (next_x < HAct) && (next_y < VAct);
    blink_d   = blink_q;
    if (first) blink_d = (blink_q == BlinkLast) ? '0 : blink_q + BW'(1);
    // Pixel (0,0) already sees the values being latched on this edge
    en_eff    = first ? ch_enable : en_q;
    bmask_eff = first ? blink_mask : bmask_q;
    blink_off = (blink_d >= BlinkHalf);
    lane_d    = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (en_eff[i] && !(bmask_eff[i] && blink_off)) begin
        lane_d[3*i +: 3] = {sprite_in[4*i+2],
                            sprite_in[4*i+1] | sprite_in[4*i+3],
                            sprite_in[4*i]   | sprite_in[4*i+3]};
      end
    end
  end

  logic       any_vis;
  logic [2:0] or_bits, pri_bits;
  logic [3:0] cnt [3];

  always_comb begin
    any_vis  = |lane_q;
    or_bits  = '0;
    pri_bits = '0;
    for (int c = 0; c < 3; c++) cnt[c] = '0;
    // Descending scan so the lowest-index visible lane wins
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      or_bits = or_bits | lane_q[3*i +: 3];
      if (lane_q[3*i +: 3] != 3'b000) pri_bits = lane_q[3*i +: 3];
      for (int c = 0; c < 3; c++) cnt[c] = cnt[c] + 4'(lane_q[3*i+c]);
    end
    for (int c = 0; c < 3; c++) begin
      col_d[c] = '0;
      if (!act_q) begin
        col_d[c] = '0;
      end else if (!any_vis) begin
        col_d[c] = bg_q[(2-c)*CDEPTH +: CDEPTH];
      end else begin
        unique case (mode_q)
          2'b00:   col_d[c] = or_bits[c] ? Fs : '0;
          // Two or more half-scale contributions already exceed full scale
          2'b10:   col_d[c] = (cnt[c] == 4'd0) ? '0 : (cnt[c] == 4'd1) ? Half : Fs;
          default: col_d[c] = pri_bits[c] ? Fs : '0;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_25 or negedge reset) begin
    if (!reset) begin
      mode_q      <= 2'b00;
      en_q        <= '0;
      bmask_q     <= '0;
      bg_q        <= '0;
      blink_q     <= '0;
      lane_q      <= '0;
      act_q       <= 1'b0;
      first_q     <= 1'b0;
      R_in        <= '0;
      G_in        <= '0;
      B_in        <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (first) begin
        mode_q  <= mode;
        en_q    <= ch_enable;
        bmask_q <= blink_mask;
        bg_q    <= bg_color;
      end
      blink_q     <= blink_d;
      lane_q      <= lane_d;
      act_q       <= active;
      first_q     <= first;
      R_in        <= col_d[0];
      G_in        <= col_d[1];
      B_in        <= col_d[2];
      pix_valid   <= act_q;
      frame_start <= first_q;
    end
  end

endmodule
